// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequenced ALU: default datapath
//               width, opcode encodings and controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Default operand/result width and matching shift-amount width
  localparam int ALU_WIDTH     = 16;
  localparam int ALU_SHW       = 4;

  // Opcode encodings
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Controller states: idle/single-cycle, or iterating a multiply
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative unsigned shift-add multiplier. One partial product
//               per step; product_o already includes the step in flight so the
//               controller can register the final result on the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CNT_W-1:0]   cnt_q;

  // Accumulator value after adding this step's partial product
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Operand shadow registers, accumulator and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign last_o    = (cnt_q == CNT_LAST);
  assign product_o = acc_d;

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequenced ALU. Single-cycle logic/arithmetic/shift ops, plus an
//               iterative WIDTH-cycle multiply with busy/start handshake.
//               res_o/flags hold between completions; res_valid_o is a
//               one-cycle load strobe for the downstream register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = ALU_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] res_o,
  output logic             res_valid_o,
  output logic             flag_z_o,
  output logic             flag_c_o,
  output logic             flag_v_o
);

  alu_state_e         state_q;
  logic               busy_q;
  logic [WIDTH-1:0]   res_q;
  logic               res_valid_q;
  logic               flag_z_q;
  logic               flag_c_q;
  logic               flag_v_q;

  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_c_d;
  logic               alu_v_d;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [2*WIDTH-1:0] shl_ext;
  logic [2*WIDTH-1:0] shr_ext;
  logic [SHW-1:0]     sh_amt;

  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;

  assign sh_amt   = b_i[SHW-1:0];
  assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_ext = {1'b0, a_i} - {1'b0, b_i};
  // The bit that leaves the word on a shift lands just outside the result
  // half of a double-width shift, so it becomes the carry with no special
  // case for a zero shift amount.
  assign shl_ext  = {{WIDTH{1'b0}}, a_i} << sh_amt;
  assign shr_ext  = {a_i, {WIDTH{1'b0}}} >> sh_amt;

  // Single-cycle result and carry/overflow for the non-multiply opcodes
  always_comb begin
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    case (op_i)
      OP_ADD: begin
        alu_res_d = sum_ext[WIDTH-1:0];
        alu_c_d   = sum_ext[WIDTH];
        alu_v_d   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_d = diff_ext[WIDTH-1:0];
        alu_c_d   = diff_ext[WIDTH];
        alu_v_d   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                    (diff_ext[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: alu_res_d = a_i & b_i;
      OP_OR:  alu_res_d = a_i | b_i;
      OP_XOR: alu_res_d = a_i ^ b_i;
      OP_SHL: begin
        alu_res_d = shl_ext[WIDTH-1:0];
        alu_c_d   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res_d = shr_ext[2*WIDTH-1:WIDTH];
        alu_c_d   = shr_ext[WIDTH-1];
      end
      default: begin
        alu_res_d = '0;
        alu_c_d   = 1'b0;
        alu_v_d   = 1'b0;
      end
    endcase
  end

  assign mul_load = (state_q == ST_IDLE) && start_i && (op_i == OP_MUL);
  assign mul_step = (state_q == ST_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .a_i       (a_i),
    .b_i       (b_i),
    .last_o    (mul_last),
    .product_o (mul_product)
  );

  // Controller FSM with registered result, flags, busy and completion strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (op_i == OP_MUL) begin
              state_q <= ST_MUL;
              busy_q  <= 1'b1;
            end else begin
              res_q       <= alu_res_d;
              flag_z_q    <= (alu_res_d == '0);
              flag_c_q    <= alu_c_d;
              flag_v_q    <= alu_v_d;
              res_valid_q <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          // start is ignored here; the last step also retires the result
          if (mul_last) begin
            res_q       <= mul_product[WIDTH-1:0];
            flag_z_q    <= (mul_product[WIDTH-1:0] == '0);
            flag_c_q    <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            flag_v_q    <= 1'b0;
            res_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;
  assign flag_z_o    = flag_z_q;
  assign flag_c_o    = flag_c_q;
  assign flag_v_o    = flag_v_q;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq: directed cases plus random
//               operations compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic [15:0] res;
  logic        res_valid;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  alu_seq #(
    .WIDTH (16),
    .SHW   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .busy_o      (busy),
    .res_o       (res),
    .res_valid_o (res_valid),
    .flag_z_o    (flag_z),
    .flag_c_o    (flag_c),
    .flag_v_o    (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic from the opcode definitions
  function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int   ux, uy, sx, sy, full, sh;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    sh = int'(y[3:0]);
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      3'd0: begin
        full = ux + uy;
        e.r  = full[15:0];
        e.c  = (full > 65535);
        e.v  = ((sx + sy) > 32767) || ((sx + sy) < -32768);
      end
      3'd1: begin
        full = ux - uy;
        e.r  = full[15:0];
        e.c  = (ux < uy);
        e.v  = ((sx - sy) > 32767) || ((sx - sy) < -32768);
      end
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = x ^ y;
      3'd5: begin
        full = ux * (1 << sh);
        e.r  = full[15:0];
        e.c  = (sh == 0) ? 1'b0 : (((ux >> (16 - sh)) & 1) == 1);
      end
      3'd6: begin
        full = ux / (1 << sh);
        e.r  = full[15:0];
        e.c  = (sh == 0) ? 1'b0 : (((ux >> (sh - 1)) & 1) == 1);
      end
      default: begin
        logic [31:0] p;
        p   = {16'd0, x} * {16'd0, y};
        e.r = p[15:0];
        e.c = (p[31:16] != 16'd0);
      end
    endcase
    e.z = (e.r == 16'd0);
    return e;
  endfunction

  // Issue one operation, follow it to completion and check result/timing.
  // inject>0 pulses an ADD start that many cycles into a multiply.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] x,
                        input logic [15:0] y, input int inject);
    exp_t e;
    int   lat, busy_cnt, exp_lat;
    logic changed;
    logic [15:0] pre_res;
    e = model(o, x, y);
    exp_lat = (o == 3'd7) ? 16 : 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0; changed = 1'b0;
    pre_res = res;
    while (!res_valid && lat < 40) begin
      if (busy) busy_cnt++;
      if (res !== pre_res) changed = 1'b1;
      if (inject > 0 && lat == inject) begin
        start = 1'b1; op = 3'd0; a = 16'h1111; b = 16'h2222;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check_value({tag, ".lat"},  lat, exp_lat);
    check_value({tag, ".busy"}, busy_cnt, exp_lat);
    check_value({tag, ".res"},  {16'd0, res}, {16'd0, e.r});
    check_value({tag, ".flags"}, {29'd0, flag_z, flag_c, flag_v}, {29'd0, e.z, e.c, e.v});
    if (o == 3'd7) check_value({tag, ".hold"}, {31'd0, changed}, 32'd0);
    @(posedge clk); #1;
    check_value({tag, ".pulse"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    int vcnt;
    logic [2:0] ro;
    logic [15:0] ra, rb;
    start = 1'b0; op = 3'd0; a = 16'd0; b = 16'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_value("reset.out", {12'd0, busy, res_valid, flag_z, flag_c, flag_v, res},
                {12'd0, 5'd0, 16'd0});
    @(negedge clk); rst = 1'b0;

    // Directed cases
    run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 0);
    check_value("add_wrap.val", {16'd0, res}, 32'h0000);

    // Back-to-back SUB then SHL
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 16'h8000; b = 16'h0001;
    @(posedge clk); #1;
    op = 3'd5; a = 16'h8001; b = 16'h0001;
    check_value("b2b.sub", {12'd0, res_valid, flag_z, flag_c, flag_v, res},
                {12'd0, 4'b1001, 16'h7FFF});
    @(posedge clk); #1;
    start = 1'b0;
    check_value("b2b.shl", {12'd0, res_valid, flag_z, flag_c, flag_v, res},
                {12'd0, 4'b1010, 16'h0002});
    @(posedge clk); #1;
    check_value("b2b.pulse", {31'd0, res_valid}, 32'd0);

    run_op("mul_a", 3'd7, 16'h0123, 16'h0010, 0);
    check_value("mul_a.val", {16'd0, res}, 32'h1230);
    run_op("mul_inj", 3'd7, 16'h0300, 16'h0100, 5);
    check_value("mul_inj.val", {29'd0, flag_z, flag_c, flag_v}, 32'b110);

    // Reset mid-multiply
    @(negedge clk);
    start = 1'b1; op = 3'd7; a = 16'h0FFF; b = 16'h0FFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_value("rst_mid", {12'd0, busy, res_valid, flag_z, flag_c, flag_v, res},
                {12'd0, 5'd0, 16'd0});
    @(negedge clk); rst = 1'b0;
    vcnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (res_valid) vcnt++;
    end
    check_value("rst_mid.novalid", vcnt, 0);
    run_op("post_rst_add", 3'd0, 16'h0002, 16'h0003, 0);
    check_value("post_rst_add.val", {16'd0, res}, 32'h0005);

    // Shift by zero, then idle hold
    run_op("shr0", 3'd6, 16'h00F0, 16'h0000, 0);
    vcnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (res_valid || res !== 16'h00F0) vcnt++;
    end
    check_value("shr0.hold", vcnt, 0);

    // Random operations
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'hFFFF;
        1: rb = 16'h8000;
        2: ra = 16'h0000;
        default: ;
      endcase
      run_op("rand", ro, ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_alu_seq
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequenced 16-bit ALU that sits directly upstream of the accumulator/address register stage.
- Drives that stage's data input (res) and its one-cycle load enable (res_valid).
- Single-cycle logic/arithmetic/shift ops complete in one clock.
- Multiply (low half) uses an iterative shift-add datapath over WIDTH clocks, with a busy/start handshake to the controller.

Parameters:
- WIDTH, 16: operand/result width. Must be ≥4 and a power of 2.
- SHW, 4: shift-amount width, equal to log2(WIDTH). Taken from b[SHW-1:0].

Ports:
- clk  in  1  rising-edge system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request. Sampled on rising clk; ignored while busy=1.
- op  in  3  opcode, sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B / shift amount, sampled with start
- busy  out  1  multiply in progress
- res  out  WIDTH  registered result. Holds its value until the next completion.
- res_valid  out  1  one-cycle completion strobe; drives the downstream register's load enable
- flag_z  out  1  res==0, registered with res
- flag_c  out  1  carry/borrow/shift-out/mul-overflow
- flag_v  out  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Reset (async, active-high): busy=0, res=0, res_valid=0, all flags=0, FSM=IDLE, iteration counter=0, operand shadow registers=0. Takes effect immediately, including mid-multiply. An aborted operation never raises res_valid.
- Opcodes:
  - 000 ADD: res=a+b. C=carry out. V=signed overflow.
  - 001 SUB: res=a-b. C=borrow (a<b unsigned). V=signed overflow.
  - 010 AND, 011 OR, 100 XOR: C=0, V=0.
  - 101 SHL: res=a<<b[SHW-1:0]. C=last bit shifted out; 0 if the shift amount is 0.
  - 110 SHR: logical right shift; C as for SHL.
  - 111 MUL: res=low WIDTH bits of a*b (unsigned). C=1 if the high half is nonzero. V=0.
- FSM states: IDLE, MUL.
- IDLE:
  - start=1 with op≠MUL: compute combinationally and register res/flags at that edge. res_valid=1 for exactly the following cycle. Latency 1. busy stays 0.
  - start=1 with op=MUL: latch a, b; clear the 2*WIDTH-bit accumulator; count=0; go to MUL; busy=1 from that edge.
- MUL:
  - Each edge: if multiplier bit0=1, add the multiplicand into the accumulator; shift the multiplier right and the multiplicand left; count++.
  - The edge where count reaches WIDTH-1 performs the final iteration and also registers res/flags, asserts res_valid for one cycle, clears busy, and returns to IDLE.
  - busy is high for exactly WIDTH cycles. res_valid appears WIDTH cycles after the accept edge.
- start while busy=1: ignored. No queueing, no error flag.
- start in the cycle res_valid=1 (FSM already IDLE): accepted. Back-to-back single-cycle ops give res_valid high on consecutive cycles.
- res and flags hold between completions. Only res_valid is a pulse.
- The downstream register loads on res_valid and clears otherwise. This block does not repeat res_valid.
- res_valid is never high for 2+ cycles from a single start.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_MUL
  - FSM state encoding (ST_IDLE, ST_MUL)
  - WIDTH default
- One sub-module, alu_mul_iter:
  - holds the multiplicand/multiplier/accumulator registers and the iteration counter
  - inputs: load, step
  - outputs: last, product[2*WIDTH-1:0]
- Top level contains the FSM, the single-cycle ALU mux, flag logic and output registers.

Test Plan:
- ADD a=0xFFFF b=0x0001 → next cycle res=0x0000, Z=1, C=1, V=0, res_valid high 1 cycle, busy never high.
- SUB a=0x8000 b=0x0001 → res=0x7FFF, V=1, C=0, Z=0. Then SHL a=0x8001 b=0x0001 in the very next cycle → res=0x0002, C=1; res_valid high on two consecutive cycles.
- MUL a=0x0123 b=0x0010 → busy high exactly 16 cycles, then res=0x1230, C=0, res_valid 1 cycle at accept+16.
- MUL a=0x0300 b=0x0100 → res=0x0000, Z=1, C=1. A start(ADD) pulsed mid-busy is ignored: no extra res_valid, res unchanged until MUL completes.
- Assert rst at iteration 8 of a MUL → busy/res/res_valid/flags go 0 immediately. After release, no res_valid. A fresh ADD 0x0002+0x0003 gives res=0x0005.
- Shift-by-zero SHR a=0x00F0 b=0x0000 → res=0x00F0, C=0. Hold start low 10 cycles afterwards → res stays 0x00F0, res_valid stays 0.
